checkpoint_monitor: RTL
=======================

Name: checkpoint_monitor

Overview:
- Synthesizable, parametrised successor to the testbench checkpoint watcher used in the chaos tests.
- Holds a programmable ordered list of expected values, watches a GPIO-derived bus, and advances through the list as each value is seen.
- Flags PASS when every checkpoint is seen in order, FAIL on timeout.
- Sits beside the chaos automaton in the user project so on-chip or firmware-driven self-test can run without a simulator.

Parameters:
- WIDTH, 16, width of the watched bus and of each checkpoint value.
- N_CHK, 8, maximum number of checkpoints (power of two, >=2).
- IDXW, $clog2(N_CHK), checkpoint index width.
- TW, 24, timeout/elapsed counter width.
- STABLE, 2, consecutive sampled cycles of equality required for a hit (>=1).

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  synchronous active-high reset.
- cfg_we  in  1  write checkpoint cfg_data into slot cfg_addr.
- cfg_addr  in  IDXW  checkpoint slot.
- cfg_data  in  WIDTH  expected value.
- cfg_count  in  IDXW+1  number of active checkpoints.
- timeout_limit  in  TW  cycles allowed in RUN; 0 = no timeout.
- start  in  1  begin a run.
- abort  in  1  return to IDLE.
- watch_bus  in  WIDTH  monitored bus (e.g. mprj_io[31:16]).
- busy  out  1  high in RUN.
- pass  out  1  sticky pass.
- fail  out  1  sticky fail.
- hit  out  1  one-cycle pulse per matched checkpoint.
- chk_idx  out  IDXW  index of the checkpoint being awaited.
- elapsed  out  TW  cycles spent in current or last run.

Behaviour:
- Reset: state IDLE; busy, pass, fail, hit = 0; chk_idx = 0; elapsed = 0; stability counter = 0; sample register = 0. Checkpoint memory is cleared to 0.
- watch_bus passes through one sample register (sample). Matching uses sample only.
- cfg_we is accepted in IDLE, PASS and FAIL. It is ignored in RUN.
- cfg_count greater than N_CHK is clamped to N_CHK.
- IDLE:
  - start with effective count >= 1 -> RUN; chk_idx, elapsed, stability counter cleared; pass and fail cleared.
  - start with count 0 is ignored.
- RUN, each cycle:
  - elapsed increments, saturating at all-ones.
  - If sample == mem[chk_idx], the stability counter increments; otherwise it clears.
  - When the counter reaches STABLE, a hit occurs: hit pulses for exactly one cycle, the counter clears, and chk_idx increments.
  - A hit on index count-1 -> PASS instead.
  - Latency: the value first appears on watch_bus in cycle t; hit is high in cycle t+STABLE+1.
  - If elapsed reaches timeout_limit (limit != 0) without a final hit -> FAIL.
- Hit and timeout in the same cycle: hit wins. If it was the final hit -> PASS; otherwise chk_idx advances and the next cycle goes to FAIL.
- Consecutive identical checkpoints: the counter clears after each hit, so the value must hold a further STABLE cycles for the next hit.
- PASS/FAIL: busy = 0, flag sticky, elapsed and chk_idx frozen. start -> fresh RUN.
- abort in any state -> IDLE next cycle with pass, fail, busy, hit = 0. elapsed and chk_idx are retained. abort has priority over start.
- wb_rst_i mid-run behaves exactly as reset and also clears checkpoint memory.

Optional Feature:
- Macro: CHK_MASK_EN.
- Defined: adds port cfg_mask (in, WIDTH), written with cfg_data, and per-slot mask storage. Match becomes ((sample ^ mem[i]) & mask[i]) == 0. Mask bits reset to all-ones.
- Undefined: no cfg_mask port; exact full-width compare.

Decomposition:
- Package checkpoint_monitor_pkg holds:
  - state enum (IDLE, RUN, PASS, FAIL);
  - default parameter constants;
  - a localparam for the saturating elapsed maximum.
- One sub-module is natural: chk_stable_match. It takes sample, expected, mask and enable; it owns the stability counter and emits the hit pulse.

Test Plan:
- Load AB40, AB41, 0000, FFFF, AB51, count=5, STABLE=2, limit=10000. Drive each value for 4 cycles in order -> five hit pulses, chk_idx 0..4, pass=1, fail=0.
- Same load with the bus stuck at AB41 and limit=500 -> no hit, fail=1 at elapsed=500, chk_idx=0.
- Drive AB40 for 1 cycle only (glitch), then 0000 -> no hit with STABLE=2. AB40 held for 2 cycles -> hit exactly 3 cycles after first appearance.
- Final checkpoint matched in the same cycle elapsed hits the limit -> pass=1, fail=0.
- abort at chk_idx=2 mid-run, then start -> chk_idx=0, elapsed restarts from 0, flags clear. cfg_we during RUN leaves memory unchanged.
- With CHK_MASK_EN: checkpoint AB00, mask FF00; bus AB5A held -> hit. Bus AC5A -> no hit.

Source files
------------

// File: rtl/checkpoint_monitor_pkg.sv
// Shared types and default constants for the checkpoint monitor.
// Build option CHK_MASK_EN (see checkpoint_monitor.sv) adds per-slot compare masks.
package checkpoint_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } state_e;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_N_CHK  = 8;
  localparam int DEF_TW     = 24;
  localparam int DEF_STABLE = 2;

  localparam logic [DEF_TW-1:0] DEF_ELAPSED_MAX = {DEF_TW{1'b1}};

endpackage

// File: rtl/checkpoint_monitor_stable_match.sv
// chk_stable_match: counts consecutive matching samples and emits one hit per STABLE-long run.
// hit_now is the combinational hit event; hit is the same event registered as a one-cycle pulse.
module chk_stable_match #(
  parameter int WIDTH  = 16,
  parameter int STABLE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] sample,
  input  logic [WIDTH-1:0] expected,
  input  logic [WIDTH-1:0] mask,
  output logic             hit_now,
  output logic             hit
);

  localparam int CW = (STABLE < 2) ? 1 : $clog2(STABLE + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          hit_q, hit_d;
  logic          match;

  // The counter restarts after every hit so repeated checkpoints need a fresh stable run.
  always_comb begin
    match   = ((sample ^ expected) & mask) == '0;
    cnt_d   = '0;
    hit_now = 1'b0;
    if (en && match) begin
      if (cnt_q == CW'(STABLE - 1)) begin
        hit_now = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    hit_d = hit_now;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      hit_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      hit_q <= hit_d;
    end
  end

  assign hit = hit_q;

endmodule

// File: rtl/checkpoint_monitor.sv
// Watches a bus for an ordered list of checkpoint values; flags pass when all are seen, fail on timeout.
// Define CHK_MASK_EN to add cfg_mask and per-slot masked comparison.
module checkpoint_monitor
  import checkpoint_monitor_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int N_CHK  = DEF_N_CHK,
  parameter int IDXW   = $clog2(N_CHK),
  parameter int TW     = DEF_TW,
  parameter int STABLE = DEF_STABLE
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             cfg_we,
  input  logic [IDXW-1:0]  cfg_addr,
  input  logic [WIDTH-1:0] cfg_data,
`ifdef CHK_MASK_EN
  input  logic [WIDTH-1:0] cfg_mask,
`endif
  input  logic [IDXW:0]    cfg_count,
  input  logic [TW-1:0]    timeout_limit,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] watch_bus,
  output logic             busy,
  output logic             pass,
  output logic             fail,
  output logic             hit,
  output logic [IDXW-1:0]  chk_idx,
  output logic [TW-1:0]    elapsed
);

  localparam logic [TW-1:0]  ELAPSED_MAX = {TW{1'b1}};
  localparam logic [IDXW:0]  COUNT_MAX   = (IDXW + 1)'(N_CHK);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  sample_q, sample_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [TW-1:0]     elapsed_q, elapsed_d;
  logic [IDXW:0]     count_q, count_d;
  logic [WIDTH-1:0]  mem_q [N_CHK];
  logic [WIDTH-1:0]  mem_d [N_CHK];
`ifdef CHK_MASK_EN
  logic [WIDTH-1:0]  mask_q [N_CHK];
  logic [WIDTH-1:0]  mask_d [N_CHK];
`endif

  logic [IDXW:0]     eff_count;
  logic [WIDTH-1:0]  cur_mask;
  logic [TW-1:0]     elapsed_inc;
  logic              cfg_ok;
  logic              match_en;
  logic              hit_now;
  logic              final_hit;
  logic              timed_out;

  assign eff_count   = (cfg_count > COUNT_MAX) ? COUNT_MAX : cfg_count;
  assign cfg_ok      = cfg_we && (state_q != ST_RUN);
  assign match_en    = (state_q == ST_RUN) && !abort;
  assign final_hit   = ({1'b0, idx_q} == (count_q - 1'b1));
  assign elapsed_inc = (elapsed_q == ELAPSED_MAX) ? elapsed_q : elapsed_q + 1'b1;
  assign timed_out   = (timeout_limit != '0) && (elapsed_inc >= timeout_limit);

`ifdef CHK_MASK_EN
  assign cur_mask = mask_q[idx_q];
`else
  assign cur_mask = '1;
`endif

  chk_stable_match #(
    .WIDTH  (WIDTH),
    .STABLE (STABLE)
  ) u_match (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .en       (match_en),
    .sample   (sample_q),
    .expected (mem_q[idx_q]),
    .mask     (cur_mask),
    .hit_now  (hit_now),
    .hit      (hit)
  );

  always_comb begin
    sample_d = watch_bus;
    mem_d    = mem_q;
    if (cfg_ok) begin
      mem_d[cfg_addr] = cfg_data;
    end
`ifdef CHK_MASK_EN
    mask_d = mask_q;
    if (cfg_ok) begin
      mask_d[cfg_addr] = cfg_mask;
    end
`endif
  end

  // A hit beats a same-cycle timeout; a non-final hit leaves the overdue timeout to fire next cycle.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    elapsed_d = elapsed_q;
    count_d   = count_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_RUN: begin
          elapsed_d = elapsed_inc;
          if (hit_now) begin
            if (final_hit) begin
              state_d = ST_PASS;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else if (timed_out) begin
            state_d = ST_FAIL;
          end
        end
        default: begin
          if (start && (eff_count != '0)) begin
            state_d   = ST_RUN;
            idx_d     = '0;
            elapsed_d = '0;
            count_d   = eff_count;
          end
        end
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= ST_IDLE;
      sample_q  <= '0;
      idx_q     <= '0;
      elapsed_q <= '0;
      count_q   <= '0;
      for (int i = 0; i < N_CHK; i++) begin
        mem_q[i] <= '0;
`ifdef CHK_MASK_EN
        mask_q[i] <= '1;
`endif
      end
    end else begin
      state_q   <= state_d;
      sample_q  <= sample_d;
      idx_q     <= idx_d;
      elapsed_q <= elapsed_d;
      count_q   <= count_d;
      mem_q     <= mem_d;
`ifdef CHK_MASK_EN
      mask_q    <= mask_d;
`endif
    end
  end

  assign busy    = (state_q == ST_RUN);
  assign pass    = (state_q == ST_PASS);
  assign fail    = (state_q == ST_FAIL);
  assign chk_idx = idx_q;
  assign elapsed = elapsed_q;

endmodule
